// File: rtl/brq_pkg.sv
// Shared types for the branch resolve queue: 32-bit word, queue entry layout.
package brq_pkg;

  typedef logic [31:0] Word;

  typedef struct packed {
    Word pc;
    Word instr;
    Word pred_pc;
  } Entry;

  localparam int unsigned ENTRY_W = $bits(Entry);

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch-enqueue and execute-resolve handshake bundle for branch_resolve_queue.
// master: fetch/execute side; slave: the queue.
interface branch_resolve_queue_if;
  import brq_pkg::*;

  logic enq_valid;
  logic enq_ready;
  Word  enq_pc;
  Word  enq_instr;
  Word  enq_pred_pc;
  logic res_valid;
  Word  res_pc;
  Word  res_next_pc;

  modport master (
    output enq_valid, enq_pc, enq_instr, enq_pred_pc,
    output res_valid, res_pc, res_next_pc,
    input  enq_ready
  );

  modport slave (
    input  enq_valid, enq_pc, enq_instr, enq_pred_pc,
    input  res_valid, res_pc, res_next_pc,
    output enq_ready
  );

endinterface

// File: rtl/brq_entry_ram.sv
// Entry storage for branch_resolve_queue: DEPTH x Entry, one synchronous
// write port at the tail, one asynchronous read port at the head.
module brq_entry_ram
  import brq_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  Entry             wdata,
  input  logic [PTR_W-1:0] raddr,
  output Entry             rdata
);

  Entry mem_q [DEPTH];

  // Write the fetched entry into its tail slot.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order tracker of fetched instructions and predicted next PCs.
// Pops the head on resolve, compares the prediction, raises a one-cycle
// redirect and flushes the whole queue on a mispredict, and drives the
// registered predictor update bus.
// Optional feature macro: BRQ_PERF_EN adds perf_resolved / perf_miss counters.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  branch_resolve_queue_if.slave    bus,
  output logic                     redirect,
  output Word                      redirect_pc,
  output logic                     upd_en,
  output logic                     miss,
  output Word                      last_pc,
  output Word                      last_instr,
  output logic                     desync,
  output logic [PTR_W:0]           count
`ifdef BRQ_PERF_EN
  ,
  output Word                      perf_resolved,
  output Word                      perf_miss
`endif
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             redirect_q, redirect_d;
  Word              redirect_pc_q, redirect_pc_d;
  logic             upd_en_q, upd_en_d;
  logic             miss_q, miss_d;
  Word              last_pc_q, last_pc_d;
  Word              last_instr_q, last_instr_d;
  logic             desync_q, desync_d;

  logic do_enq, do_pop, mispred, ram_we;
  Entry head_e, wr_e;

  // Fullness is judged on the current count only; a same-cycle pop does not free a slot.
  assign bus.enq_ready = (count_q != CNT_W'(DEPTH));

  brq_entry_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (tail_q),
    .wdata (wr_e),
    .raddr (head_q),
    .rdata (head_e)
  );

  // Pointer/count update, prediction compare and next values of the output registers.
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    redirect_pc_d = redirect_pc_q;
    last_pc_d     = last_pc_q;
    last_instr_d  = last_instr_q;

    wr_e.pc      = bus.enq_pc;
    wr_e.instr   = bus.enq_instr;
    wr_e.pred_pc = bus.enq_pred_pc;

    do_enq  = bus.enq_valid && bus.enq_ready;
    do_pop  = bus.res_valid && (count_q != '0);
    mispred = do_pop && (bus.res_next_pc != head_e.pred_pc);
    // A mispredict discards everything younger, including a same-cycle enqueue.
    ram_we  = do_enq && !mispred;

    if (mispred) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (do_pop) head_d = head_q + PTR_W'(1);
      if (ram_we) tail_d = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(ram_we) - CNT_W'(do_pop);
    end

    upd_en_d   = do_pop;
    miss_d     = mispred;
    redirect_d = mispred;
    if (mispred) redirect_pc_d = bus.res_next_pc;
    if (do_pop) begin
      last_pc_d    = head_e.pc;
      last_instr_d = head_e.instr;
    end

    // Any resolve that does not line up with the head poisons the tracker until reset.
    desync_d = desync_q ||
               (bus.res_valid && ((count_q == '0) || (bus.res_pc != head_e.pc)));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      upd_en_q      <= 1'b0;
      miss_q        <= 1'b0;
      last_pc_q     <= '0;
      last_instr_q  <= '0;
      desync_q      <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      upd_en_q      <= upd_en_d;
      miss_q        <= miss_d;
      last_pc_q     <= last_pc_d;
      last_instr_q  <= last_instr_d;
      desync_q      <= desync_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign upd_en      = upd_en_q;
  assign miss        = miss_q;
  assign last_pc     = last_pc_q;
  assign last_instr  = last_instr_q;
  assign desync      = desync_q;
  assign count       = count_q;

`ifdef BRQ_PERF_EN
  Word perf_resolved_q, perf_resolved_d;
  Word perf_miss_q, perf_miss_d;

  // Saturating counters driven by the registered update pulse.
  always_comb begin
    perf_resolved_d = perf_resolved_q;
    perf_miss_d     = perf_miss_q;
    if (upd_en_q && (perf_resolved_q != '1)) perf_resolved_d = perf_resolved_q + 32'd1;
    if (upd_en_q && miss_q && (perf_miss_q != '1)) perf_miss_d = perf_miss_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_resolved_q <= '0;
      perf_miss_q     <= '0;
    end else begin
      perf_resolved_q <= perf_resolved_d;
      perf_miss_q     <= perf_miss_d;
    end
  end

  assign perf_resolved = perf_resolved_q;
  assign perf_miss     = perf_miss_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH = 8).
module tb_branch_resolve_queue;
  import brq_pkg::*;

  logic       clk;
  logic       reset;
  logic       redirect;
  Word        redirect_pc;
  logic       upd_en;
  logic       miss;
  Word        last_pc;
  Word        last_instr;
  logic       desync;
  logic [3:0] count;
`ifdef BRQ_PERF_EN
  Word        perf_resolved;
  Word        perf_miss;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  branch_resolve_queue_if bus ();

  branch_resolve_queue #(.DEPTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .upd_en      (upd_en),
    .miss        (miss),
    .last_pc     (last_pc),
    .last_instr  (last_instr),
    .desync      (desync),
    .count       (count)
`ifdef BRQ_PERF_EN
    ,
    .perf_resolved (perf_resolved),
    .perf_miss     (perf_miss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic Word instr_of(input Word pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // One clock: drive inputs, take the edge, leave #1 for outputs to settle.
  task automatic step(input logic ev, input Word epc, input Word epred,
                      input logic rv, input Word rpc, input Word rnext);
    bus.enq_valid   = ev;
    bus.enq_pc      = epc;
    bus.enq_instr   = instr_of(epc);
    bus.enq_pred_pc = epred;
    bus.res_valid   = rv;
    bus.res_pc      = rpc;
    bus.res_next_pc = rnext;
    @(posedge clk);
    #1;
    bus.enq_valid = 1'b0;
    bus.res_valid = 1'b0;
  endtask

  task automatic enq(input Word pc, input Word pred);
    step(1'b1, pc, pred, 1'b0, '0, '0);
  endtask

  task automatic res(input Word rpc, input Word rnext);
    step(1'b0, '0, '0, 1'b1, rpc, rnext);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.enq_valid = 1'b0; bus.enq_pc = '0; bus.enq_instr = '0; bus.enq_pred_pc = '0;
    bus.res_valid = 1'b0; bus.res_pc = '0; bus.res_next_pc = '0;
    #2;
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;

    // Reset state
    chk("rst_count", count, 4'd0);
    chk("rst_upd_en", upd_en, 1'b0);
    chk("rst_redirect", redirect, 1'b0);
    chk("rst_miss", miss, 1'b0);
    chk("rst_desync", desync, 1'b0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_last_pc", last_pc, 32'h0);
    chk("rst_enq_ready", bus.enq_ready, 1'b1);

    // Correct prediction
    enq(32'h0040_0000, 32'h0040_0004);
    chk("t1_count1", count, 4'd1);
    res(32'h0040_0000, 32'h0040_0004);
    chk("t1_upd_en", upd_en, 1'b1);
    chk("t1_miss", miss, 1'b0);
    chk("t1_redirect", redirect, 1'b0);
    chk("t1_last_pc", last_pc, 32'h0040_0000);
    chk("t1_last_instr", last_instr, 32'hA5E5_0000);
    chk("t1_count0", count, 4'd0);
    idle();
    chk("t1_upd_pulse", upd_en, 1'b0);

    // Mispredict flushes three entries
    enq(32'h0040_0010, 32'h0040_0004);
    enq(32'h0040_0014, 32'h0040_0018);
    enq(32'h0040_0018, 32'h0040_001C);
    chk("t2_count3", count, 4'd3);
    res(32'h0040_0010, 32'h0040_0100);
    chk("t2_miss", miss, 1'b1);
    chk("t2_redirect", redirect, 1'b1);
    chk("t2_redirect_pc", redirect_pc, 32'h0040_0100);
    chk("t2_upd_en", upd_en, 1'b1);
    chk("t2_count0", count, 4'd0);
    idle();
    chk("t2_redirect_pulse", redirect, 1'b0);
    chk("t2_no_upd", upd_en, 1'b0);
    chk("t2_desync", desync, 1'b0);

    // Fill to DEPTH, overflow attempt, then resolves across pointer wrap
    for (int i = 0; i < 8; i++) enq(32'h0000_1000 + 32'(4 * i), 32'h0000_1004 + 32'(4 * i));
    chk("t3_full_count", count, 4'd8);
    chk("t3_full_ready", bus.enq_ready, 1'b0);
    enq(32'h0000_2000, 32'h0000_2004);
    chk("t3_ovf_count", count, 4'd8);
    // At full the enqueue is refused (no bypass), only the pop lands.
    step(1'b1, 32'h0000_3000, 32'h0000_3004, 1'b1, 32'h0000_1000, 32'h0000_1004);
    chk("t3_full_pop_count", count, 4'd7);
    chk("t3_full_pop_pc", last_pc, 32'h0000_1000);
    chk("t3_full_pop_miss", miss, 1'b0);
    // Below full, enqueue and correct resolve together leave count unchanged.
    step(1'b1, 32'h0000_1020, 32'h0000_1024, 1'b1, 32'h0000_1004, 32'h0000_1008);
    chk("t3_both_count", count, 4'd7);
    chk("t3_both_pc", last_pc, 32'h0000_1004);
    for (int i = 2; i < 9; i++) begin
      res(32'h0000_1000 + 32'(4 * i), 32'h0000_1004 + 32'(4 * i));
      chk("t3_drain_pc", last_pc, 32'h0000_1000 + 32'(4 * i));
      chk("t3_drain_miss", miss, 1'b0);
    end
    chk("t3_empty", count, 4'd0);
    chk("t3_desync", desync, 1'b0);

    // Enqueue + mispredicting resolve in the same cycle
    enq(32'h0000_3000, 32'h0000_3004);
    step(1'b1, 32'h0000_3004, 32'h0000_3008, 1'b1, 32'h0000_3000, 32'h0000_5000);
    chk("t4_count", count, 4'd0);
    chk("t4_redirect", redirect, 1'b1);
    chk("t4_redirect_pc", redirect_pc, 32'h0000_5000);
    // Enqueue during the redirect cycle is accepted.
    enq(32'h0000_5000, 32'h0000_5004);
    chk("t4_redir_enq", count, 4'd1);
    res(32'h0000_5000, 32'h0000_5004);
    chk("t4_redir_pc", last_pc, 32'h0000_5000);
    chk("t4_redir_miss", miss, 1'b0);

    // Desync: resolve on empty queue
    res(32'h0000_7000, 32'h0000_7004);
    chk("t5_empty_desync", desync, 1'b1);
    chk("t5_empty_upd", upd_en, 1'b0);
    chk("t5_empty_count", count, 4'd0);
    idle();
    chk("t5_sticky", desync, 1'b1);
    do_reset();
    chk("t5_rst_desync", desync, 1'b0);

    // Desync: pc mismatch still pops and updates
    enq(32'h0000_6000, 32'h0000_6004);
    res(32'h0000_6100, 32'h0000_6004);
    chk("t6_desync", desync, 1'b1);
    chk("t6_upd_en", upd_en, 1'b1);
    chk("t6_miss", miss, 1'b0);
    chk("t6_last_pc", last_pc, 32'h0000_6000);
    chk("t6_count", count, 4'd0);
    idle();
    chk("t6_sticky", desync, 1'b1);

    // Reset mid-operation with entries queued
    do_reset();
    for (int i = 0; i < 4; i++) enq(32'h0000_8000 + 32'(4 * i), 32'h0000_8004 + 32'(4 * i));
    chk("t7_count4", count, 4'd4);
    do_reset();
    chk("t7_count0", count, 4'd0);
    chk("t7_redirect", redirect, 1'b0);
    chk("t7_upd_en", upd_en, 1'b0);
    idle();
    chk("t7_redirect_after", redirect, 1'b0);

`ifdef BRQ_PERF_EN
    // 10 resolves, misses at i = 2, 5, 8
    for (int i = 0; i < 10; i++) begin
      enq(32'h0000_9000 + 32'(16 * i), 32'h0000_9004 + 32'(16 * i));
      if (i == 2 || i == 5 || i == 8)
        res(32'h0000_9000 + 32'(16 * i), 32'h0000_F000);
      else
        res(32'h0000_9000 + 32'(16 * i), 32'h0000_9004 + 32'(16 * i));
    end
    idle();
    idle();
    chk("p_resolved", perf_resolved, 32'd10);
    chk("p_miss", perf_miss, 32'd3);
    for (int i = 0; i < 4; i++) enq(32'h0000_A000 + 32'(4 * i), 32'h0000_A004 + 32'(4 * i));
    do_reset();
    chk("p_rst_count", count, 4'd0);
    chk("p_rst_resolved", perf_resolved, 32'd0);
    chk("p_rst_miss", perf_miss, 32'd0);
    chk("p_rst_redirect", redirect, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
